// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the new data
// (write-first), so the FIFO can treat rdata_o as "current contents of raddr".
//
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address, sampled at the clock edge
//   rdata_o  - registered read data
module sdp_ram #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned Depth     = 15
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_fifo_sync.sv
// Single-clock FIFO turning a valid-only (no backpressure) stream into a
// valid/ready stream. Storage is a (DEPTH-1)-entry RAM plus a registered
// output stage, DEPTH words in total. First-word-fall-through with 1 cycle
// latency. Words arriving while full (and not being popped) are dropped and
// flagged with a sticky overflow bit.
//
// Ports:
//   clk            - clock
//   arst           - asynchronous active-high reset
//   up_valid       - input word present (cannot be stalled)
//   up_data        - input word
//   down_valid     - down_data holds a valid word
//   down_ready     - consumer accepts when down_valid && down_ready
//   down_data      - head-of-FIFO word, registered
//   count          - words held (0..DEPTH), including the output register
//   overflow       - sticky: a word was dropped
//   clear_overflow - synchronous clear of overflow (a same-cycle drop wins)
module stream_fifo_sync #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  down_valid,
  input  logic                  down_ready,
  output logic [DATA_WIDTH-1:0] down_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned MEM_DEPTH = DEPTH - 1;
  localparam logic [ADDR_WIDTH-1:0] PtrLast   = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CountFull = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  ovf_q, ovf_d;

  logic                  pop, full, push, drop, load_out, mem_empty;
  logic                  mem_we, mem_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Pointers wrap at the memory size, which is not a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PtrLast) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign count = {1'b0, mem_cnt_q} + {{ADDR_WIDTH{1'b0}}, out_valid_q};

  always_comb begin
    pop       = out_valid_q & down_ready;
    full      = (count == CountFull);
    push      = up_valid & (~full | pop);
    drop      = up_valid & full & ~pop;
    load_out  = ~out_valid_q | pop;
    mem_empty = (mem_cnt_q == '0);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    mem_rd      = 1'b0;

    if (load_out) begin
      if (!mem_empty) begin
        // Memory holds older words: refill output from the head.
        mem_rd      = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = mem_rdata;
        rd_ptr_d    = ptr_inc(rd_ptr_q);
        mem_we      = push;
      end else begin
        // Nothing older stored: incoming word bypasses the memory.
        out_valid_d = push;
        if (push) begin
          out_data_d = up_data;
        end
      end
    end else begin
      mem_we = push;
    end

    if (mem_we) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (mem_we && !mem_rd) begin
      mem_cnt_d = mem_cnt_q + ADDR_WIDTH'(1);
    end else if (!mem_we && mem_rd) begin
      mem_cnt_d = mem_cnt_q - ADDR_WIDTH'(1);
    end

    ovf_d = drop | (ovf_q & ~clear_overflow);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Read address is the next head so rdata always reflects the current head.
  sdp_ram #(
    .DataWidth(DATA_WIDTH),
    .AddrWidth(ADDR_WIDTH),
    .Depth    (MEM_DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(up_data),
    .raddr_i(rd_ptr_d),
    .rdata_o(mem_rdata)
  );

  assign down_valid = out_valid_q;
  assign down_data  = out_data_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stream_fifo_sync.sv
module tb_stream_fifo_sync;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        up_valid = 1'b0;
  logic [15:0] up_data = '0;
  logic        down_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        down_valid;
  logic [15:0] down_data;
  logic [4:0]  count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  // Reference model: queue of held words (head = q[0]) plus sticky flag.
  int unsigned q[$];
  bit          m_ovf = 1'b0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        c;
    int          e_cnt;
    logic        e_val;
    logic [15:0] e_dat;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[7];

  stream_fifo_sync #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .up_valid      (up_valid),
    .up_data       (up_data),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_data     (down_data),
    .count         (count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model by the FIFO rules, compare after edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic r, input logic c);
    bit mpop, mfull, macc, mdrop;
    up_valid       = v;
    up_data        = d;
    down_ready     = r;
    clear_overflow = c;
    mpop  = (q.size() > 0) && r;
    mfull = (q.size() == DEPTH);
    macc  = v && (!mfull || mpop);
    mdrop = v && mfull && !mpop;
    @(posedge clk);
    #1;
    if (mpop) void'(q.pop_front());
    if (macc) q.push_back(int'(d));
    m_ovf = mdrop ? 1'b1 : (c ? 1'b0 : m_ovf);
    check("model_count", 32'(count), 32'(q.size()));
    check("model_valid", 32'(down_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("model_data", 32'(down_data), q[0]);
    check("model_ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    up_valid       = 1'b0;
    down_ready     = 1'b0;
    clear_overflow = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(down_valid), 32'd0);
    check("rst_data", 32'(down_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
    check("post_rst_valid", 32'(down_valid), 32'd0);
  endtask

  initial begin
    int thr;

    // Test 1 and a short stall/pop mix; expected values hand-derived.
    vecs[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1, 1'b1, 16'h0001, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 16'h00A0, 1'b0, 1'b0, 1, 1'b1, 16'h00A0, 1'b0};
    vecs[3] = '{1'b1, 16'h00A1, 1'b0, 1'b0, 2, 1'b1, 16'h00A0, 1'b0};
    vecs[4] = '{1'b1, 16'h00A2, 1'b1, 1'b0, 2, 1'b1, 16'h00A1, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 16'h00A2, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_valid", i), 32'(down_valid), 32'(vecs[i].e_val));
      if (vecs[i].e_val) check($sformatf("vec%0d_data", i), 32'(down_data), 32'(vecs[i].e_dat));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Test 2: fill to DEPTH with consumer stalled.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf", 32'(overflow), 32'd0);
    check("fill_head", 32'(down_data), 32'h0010);

    // Test 3: drop while full, then clear.
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    check("drop_head", 32'(down_data), 32'h0010);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Test 4: full + simultaneous pop accepts the word.
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_head", 32'(down_data), 32'h0011);
    for (int i = 0; i < 15; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("beef_last", 32'(down_data), 32'hBEEF);
    check("beef_count", 32'(count), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("drain_count", 32'(count), 32'd0);

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'h0BAD, 1'b0, 1'b1);
    check("setwins_ovf", 32'(overflow), 32'd1);

    // Test 5: randomized traffic against the model, varying consumer pressure.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 3)
        0:       thr = 20;
        1:       thr = 50;
        default: thr = 85;
      endcase
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 99) < thr),
            1'($urandom_range(0, 99) < 3));
    end

    // Test 6: reset mid-burst with 7 words held.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd7);
    do_reset();
    cycle(1'b1, 16'h7777, 1'b1, 1'b0);
    check("after_rst_first", 32'(down_data), 32'h7777);
    check("after_rst_count", 32'(count), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check("after_rst_empty", 32'(down_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo_sync.md
Name: stream_fifo_sync

Overview:
- Single-clock FIFO that sits directly downstream of the cross-clock circular buffer, in the consumer clock domain.
- The circular buffer produces a valid-only stream with no backpressure. This block stores that stream and re-issues it over a valid/ready handshake, so downstream logic may stall.
- Words that arrive while the FIFO is full are dropped and flagged with a sticky overflow indication. The producer cannot be stalled.

Parameters:
DATA_WIDTH, 16, width of each data word
ADDR_WIDTH, 4, log2 of storage depth; DEPTH = 1<<ADDR_WIDTH words total capacity (minimum ADDR_WIDTH 1)

Ports:
clk  input  1  single clock for all logic
arst  input  1  asynchronous, active-high reset
up_valid  input  1  input word present this cycle; no backpressure
up_data  input  DATA_WIDTH  input word
down_valid  output  1  down_data holds a valid word
down_ready  input  1  consumer accepts the word when down_valid && down_ready
down_data  output  DATA_WIDTH  head-of-FIFO word, registered
count  output  ADDR_WIDTH+1  words held, range 0..DEPTH, includes the output register
overflow  output  1  sticky flag: a word was dropped because the FIFO was full
clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset: the interface is fixed as one clock, with an asynchronous active-high reset. While arst is high, all of the following hold immediately:
  - write/read pointers = 0, count = 0
  - down_valid = 0, down_data = 0, overflow = 0
- Reset mid-operation discards all stored words. No output transaction occurs in the reset cycle or the cycle after it.
- Definitions:
  - push = up_valid && accepted
  - pop = down_valid && down_ready
- Acceptance:
  - If count < DEPTH, the word is accepted.
  - If count == DEPTH and pop is asserted in the same cycle, the word is also accepted (full + simultaneous pop). count stays at DEPTH.
  - If count == DEPTH and there is no pop, the word is dropped and overflow sets on the next edge.
- count update per edge: count + push - pop. It never exceeds DEPTH and never underflows.
- Output stage: first-word-fall-through behaviour, built from an internal memory plus an output register.
  - Empty FIFO: a word pushed at edge N appears with down_valid = 1 after edge N. Latency is 1 cycle.
  - When the output register is empty, or is being popped, it loads the next word in order. Source priority:
    1. memory head, if the memory is non-empty
    2. otherwise, the incoming word (bypass)
  - down_valid stays high with down_data stable while down_ready is low. No word is lost, reordered or duplicated.
  - Sustained push + pop keeps throughput at 1 word/cycle, with no bubbles once non-empty.
- Memory: DEPTH-1 memory entries plus the output register give a total of DEPTH.
  - Pointers are ADDR_WIDTH-bit and wrap modulo the memory size. Wrap is handled by counter compare, not by pointer bits alone.
- overflow: sticky until clear_overflow is high at an edge. A drop in the same cycle as clear_overflow leaves overflow = 1 (set wins).
- Combinational paths: none from up_* to down_*. The only combinational dependency is down_ready affecting the acceptance decision when full.

Decomposition:
- No shared package is needed. DEPTH is a localparam derived from ADDR_WIDTH, consistent with the circular buffer.
- One natural sub-module: sdp_ram. It is a simple dual-port, one-write/one-read synchronous memory with DATA_WIDTH x (DEPTH-1) entries, registered read. It is instantiated once.
- Pointer, count and output-register control stay in stream_fifo_sync.

Test Plan:
1. Reset, then push 0x0001 with down_ready=1 -> down_valid=1, down_data=0x0001 one cycle later; count back to 0 after the pop.
2. down_ready=0, push 16 words 0x0010..0x001F (DEPTH=16) -> count=16, no overflow. Then release down_ready -> 16 words out in order, back-to-back, count=0.
3. Full FIFO, down_ready=0, push 0xDEAD -> word dropped, overflow=1, count stays 16, output order unchanged. Then clear_overflow=1 -> overflow=0 next cycle.
4. Full FIFO, push 0xBEEF with down_ready=1 in the same cycle -> accepted, overflow stays 0, count=16. 0xBEEF emerges last after the 15 older words.
5. Random up_valid (50%) and random down_ready for 10k cycles, including pointer wrap -> scoreboard shows the output sequence equals accepted inputs in order; count matches the model every cycle.
6. Assert arst mid-burst with count=7 -> down_valid=0, count=0, overflow=0 immediately. After release, the first new push is the first word out; no stale data.
